// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the unified-memory port arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   owner_t      : which pipeline port owns the selected/outstanding access
//   STARVE_CNT_W : width of the fetch anti-starvation counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
// Saturating counter of data grants issued while fetch was waiting.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (count -> 0)
//   i_inc    in   count one more D grant taken while I waited
//   i_clr    in   fetch was served or stopped asking; restart count
//   o_at_max out  count has reached MAX_VAL; fetch must win next arbitration
// -----------------------------------------------------------------------------
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_VAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(MAX_VAL);

  logic [STARVE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // '>=' keeps fetch forced even if the count ever ran past the limit.
  assign o_at_max = (r_cnt >= CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the fetch (I) and memory
// (D) pipeline stages. One transaction outstanding at a time; data has
// priority. Defining ARB_STARVE_GUARD_EN adds a fetch anti-starvation guard
// that forces an I grant after STARVE_MAX consecutive D grants while I waits.
// Ports:
//   clk, rst                  clock / asynchronous active-low reset
//   i_req,i_addr              fetch request        -> i_gnt, i_rvalid, i_rdata
//   d_req,d_we,d_addr,d_wdata data request         -> d_gnt, d_rvalid, d_rdata
//   m_req,m_we,m_addr,m_wdata memory request       <- m_gnt, m_rvalid, m_rdata
//   stall_if, stall_mem       stall requests to hazard logic
//   err_spurious              sticky: m_rvalid seen with nothing outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err_spurious
);

  arb_state_t r_state;
  logic       r_err_spurious;

  logic   w_idle;
  logic   w_force_i;
  logic   w_sel_i;
  logic   w_sel_d;
  logic   w_m_req;
  logic   w_fire;
  owner_t w_owner;

  assign w_idle = (r_state == IDLE);

`ifdef ARB_STARVE_GUARD_EN
  logic w_cnt_inc;
  logic w_cnt_clr;

  assign w_cnt_inc = d_gnt & i_req;
  assign w_cnt_clr = i_gnt | (w_idle & ~i_req);

  arb_starve_ctr #(
    .MAX_VAL (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_cnt_inc),
    .i_clr    (w_cnt_clr),
    .o_at_max (w_force_i)
  );
`else
  // Strict data priority: STARVE_MAX has no effect in this build.
  logic w_unused_starve_max;
  assign w_unused_starve_max = |STARVE_MAX;
  assign w_force_i           = 1'b0;
`endif

  // Arbitration: D wins unless the guard forces fetch through.
  assign w_sel_i = i_req & (~d_req | w_force_i);
  assign w_sel_d = d_req & ~w_sel_i;
  assign w_owner = w_sel_d ? OWN_D : OWN_I;

  // Issue is combinational and only from IDLE; reset silences it.
  assign w_m_req = rst & w_idle & (i_req | d_req);
  assign w_fire  = w_m_req & m_gnt;

  assign m_req   = w_m_req;
  assign m_we    = w_m_req & w_sel_d & d_we;
  assign m_addr  = w_sel_d ? d_addr : i_addr;
  assign m_wdata = w_sel_d ? d_wdata : '0;

  assign i_gnt = w_fire & (w_owner == OWN_I);
  assign d_gnt = w_fire & (w_owner == OWN_D);

  // Responses go straight through to the owner only; m_rvalid in IDLE is dropped.
  assign i_rvalid = rst & (r_state == BUSY_I) & m_rvalid;
  assign d_rvalid = rst & (r_state == BUSY_D) & m_rvalid;
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

  assign stall_if  = rst & i_req & ~i_gnt;
  assign stall_mem = rst & ((d_req & ~d_gnt) | ((r_state == BUSY_D) & ~m_rvalid));

  assign err_spurious = r_err_spurious;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_err_spurious <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m_rvalid) begin
            r_err_spurious <= 1'b1;
          end
          if (w_fire) begin
            r_state <= (w_owner == OWN_D) ? BUSY_D : BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // Returning to IDLE here gives the single turnaround cycle.
          if (m_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios with literal expectations, then randomized requesters and
// a randomized-latency memory. A behavioural model (owner + starve count +
// sticky error) predicts every output on every falling edge.
// Honours ARB_STARVE_GUARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 2;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_gnt = 1'b0;
  logic          m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          stall_if, stall_mem, err_spurious;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_gnt        (i_gnt),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .m_req        (m_req),
    .m_we         (m_we),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_gnt        (m_gnt),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .err_spurious (err_spurious)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mdl_busy = 0;   // 0: nothing outstanding, 1: fetch owns it, 2: data owns it
  int mdl_cnt  = 0;   // consecutive D grants while fetch was waiting
  bit mdl_err  = 1'b0;

  function automatic bit pick_i();
    return i_req && (!d_req || (GUARD && mdl_cnt == SMAX));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_busy <= 0;
      mdl_cnt  <= 0;
      mdl_err  <= 1'b0;
    end else if (mdl_busy == 0) begin
      if (m_rvalid) mdl_err <= 1'b1;
      if ((i_req || d_req) && m_gnt) begin
        mdl_busy <= pick_i() ? 1 : 2;
        if (pick_i() || !i_req) mdl_cnt <= 0;
        else                    mdl_cnt <= (mdl_cnt < 15) ? mdl_cnt + 1 : 15;
      end else if (!i_req) begin
        mdl_cnt <= 0;
      end
    end else if (m_rvalid) begin
      mdl_busy <= 0;
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin : cmp
    bit wi, wd, mr, ig, dg, irv, drv;
    if (chk_en) begin
      wi  = pick_i();
      wd  = d_req && !wi;
      mr  = rst && (mdl_busy == 0) && (i_req || d_req);
      ig  = mr && m_gnt && wi;
      dg  = mr && m_gnt && wd;
      irv = rst && (mdl_busy == 1) && m_rvalid;
      drv = rst && (mdl_busy == 2) && m_rvalid;
      chk("m_req", m_req, mr);
      chk("i_gnt", i_gnt, ig);
      chk("d_gnt", d_gnt, dg);
      chk("i_rvalid", i_rvalid, irv);
      chk("d_rvalid", d_rvalid, drv);
      if (mr) begin
        chk("m_addr", m_addr, wd ? d_addr : i_addr);
        chk("m_we", m_we, wd && d_we);
        if (wd) chk("m_wdata", m_wdata, d_wdata);
      end
      if (irv) chk("i_rdata", i_rdata, m_rdata);
      if (drv) chk("d_rdata", d_rdata, m_rdata);
      if (!rst) begin
        chk("i_rdata_rst", i_rdata, 0);
        chk("d_rdata_rst", d_rdata, 0);
      end
      chk("stall_if", stall_if, rst && i_req && !ig);
      chk("stall_mem", stall_mem, rst && ((d_req && !dg) || (mdl_busy == 2 && !m_rvalid)));
      chk("err_spurious", err_spurious, mdl_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            got [6];
    int            exp_g;
    int            pend;
    bit            pend_we;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] mem [64];
    bit            fire, f_we, ig_s, dg_s;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wd;

    chk_en = 1'b1;

    // Reset with everything asking: nothing may leak out.
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b1;
    tick();
    neg();
    chk("rst_m_req", m_req, 0);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_mem", stall_mem, 0);
    chk("rst_err", err_spurious, 0);
    tick();
    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    rst = 1'b1;
    tick();

    // I-only read of 0x100, data 2 cycles after grant.
    i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
    neg();
    chk("t1_i_gnt", i_gnt, 1);
    chk("t1_m_addr", m_addr, 32'h100);
    chk("t1_m_we", m_we, 0);
    tick();
    i_req = 1'b0; m_gnt = 1'b0;
    neg();
    chk("t1_c1_i_rvalid", i_rvalid, 0);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; i_req = 1'b1; i_addr = 32'h104; m_gnt = 1'b1;
    neg();
    chk("t1_c2_i_rvalid", i_rvalid, 1);
    chk("t1_c2_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_c2_d_rvalid", d_rvalid, 0);
    chk("t1_c2_m_req", m_req, 0);
    chk("t1_c2_i_gnt", i_gnt, 0);
    tick();
    m_rvalid = 1'b0; m_rdata = '0;
    neg();
    chk("t1_c3_i_gnt", i_gnt, 1);
    tick();
    i_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234;
    tick();
    m_rvalid = 1'b0;

    // Simultaneous I read and D write: D first, I after the turnaround.
    i_req = 1'b1; i_addr = 32'h108;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55; m_gnt = 1'b1;
    neg();
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_i_gnt", i_gnt, 0);
    chk("t2_m_we", m_we, 1);
    chk("t2_m_addr", m_addr, 32'h200);
    chk("t2_m_wdata", m_wdata, 32'h55);
    chk("t2_stall_if", stall_if, 1);
    tick();
    d_req = 1'b0; d_we = 1'b0;
    neg();
    chk("t2_busy_i_gnt", i_gnt, 0);
    tick();
    m_rvalid = 1'b1;
    neg();
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_turn_i_gnt", i_gnt, 0);
    chk("t2_i_rvalid", i_rvalid, 0);
    tick();
    m_rvalid = 1'b0;
    neg();
    chk("t2_late_i_gnt", i_gnt, 1);
    chk("t2_late_m_addr", m_addr, 32'h108);
    tick();
    i_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;

    // Both held continuously, one-cycle memory: grant order.
    i_req = 1'b1; i_addr = 32'h10C; d_req = 1'b1; d_addr = 32'h204; m_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      neg();
      got[k] = d_gnt ? 2 : (i_gnt ? 1 : 0);
      tick();
      m_rvalid = 1'b1;
      tick();
      m_rvalid = 1'b0;
    end
    for (int k = 0; k < 6; k++) begin
      exp_g = (GUARD && (k % 3 == 2)) ? 1 : 2;
      chk($sformatf("t3_grant%0d", k), got[k], exp_g);
    end
    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
    tick();

    // Memory refuses for 3 cycles.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; m_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("t4_m_req", m_req, 1);
      chk("t4_m_addr", m_addr, 32'h300);
      chk("t4_stall_mem", stall_mem, 1);
      chk("t4_d_gnt", d_gnt, 0);
      tick();
    end
    m_gnt = 1'b1;
    neg();
    chk("t4_d_gnt_final", d_gnt, 1);
    chk("t4_stall_mem_gnt", stall_mem, 0);
    tick();
    d_req = 1'b0; m_gnt = 1'b0;
    neg();
    chk("t4_busy_stall_mem", stall_mem, 1);

    // Reset in BUSY_D, then the abandoned response arrives.
    tick();
    rst = 1'b0;
    neg();
    chk("t5_rst_stall_mem", stall_mem, 0);
    chk("t5_rst_d_rvalid", d_rvalid, 0);
    tick();
    rst = 1'b1;
    tick();
    m_rvalid = 1'b1; m_rdata = 32'hABCD;
    neg();
    chk("t5_late_d_rvalid", d_rvalid, 0);
    chk("t5_late_i_rvalid", i_rvalid, 0);
    chk("t5_err_not_yet", err_spurious, 0);
    tick();
    m_rvalid = 1'b0; d_req = 1'b1; d_addr = 32'h304; m_gnt = 1'b1;
    neg();
    chk("t5_err_set", err_spurious, 1);
    chk("t5_idle_d_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1;
    neg();
    chk("t5_real_d_rvalid", d_rvalid, 1);
    chk("t5_err_sticky", err_spurious, 1);
    tick();
    m_rvalid = 1'b0;

    // Request withdrawn before the memory accepts it.
    d_req = 1'b1; d_addr = 32'h400; m_gnt = 1'b0;
    neg();
    chk("t6_m_req", m_req, 1);
    chk("t6_d_gnt", d_gnt, 0);
    tick();
    d_req = 1'b0; m_gnt = 1'b1;
    neg();
    chk("t6_wd_m_req", m_req, 0);
    chk("t6_wd_d_gnt", d_gnt, 0);
    tick();
    m_gnt = 1'b0;
    neg();
    chk("t6_idle_stall_mem", stall_mem, 0);

    // Reset clears the sticky error.
    tick();
    rst = 1'b0;
    tick();
    neg();
    chk("t7_err_cleared", err_spurious, 0);
    tick();
    rst = 1'b1;

    // Randomized requesters and memory with latency 1..3.
    for (int a = 0; a < 64; a++) mem[a] = $urandom;
    pend = 0; pend_we = 1'b0; pend_data = '0;
    for (int c = 0; c < 4000; c++) begin
      neg();
      fire   = m_req && m_gnt;
      f_we   = m_we;
      f_addr = m_addr;
      f_wd   = m_wdata;
      ig_s   = i_gnt;
      dg_s   = d_gnt;
      tick();
      if (fire) begin
        if (f_we) mem[f_addr[7:2]] = f_wd;
        else      pend_data = mem[f_addr[7:2]];
        pend_we = f_we;
        pend    = $urandom_range(1, 3);
      end
      m_rvalid = 1'b0;
      m_rdata  = $urandom;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = pend_we ? '0 : pend_data;
        end
      end
      m_gnt = ($urandom_range(0, 3) != 0);
      if (!i_req || ig_s) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = 32'($urandom_range(0, 63)) << 2;
      end else if ($urandom_range(0, 15) == 0) begin
        i_req = 1'b0;
      end
      if (!d_req || dg_s) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = ($urandom_range(0, 1) != 0);
        d_addr  = 32'($urandom_range(0, 63)) << 2;
        d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst = 1'b0;
    end

    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0; rst = 1'b1;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
